pdm_audio_capture: RTL and testbench
====================================

Name: pdm_audio_capture

Overview:
- Parametrised successor to the tuner's single-mic PDM audio grabber.
- Generates the PDM mic clock and decimates 1-bit PDM into multi-bit PCM by counting ones per frame.
- Supports mono (one selectable channel) or stereo (L/R interleaved), single-shot or continuous ring capture.
- Writes samples into the sample RAM that feeds the pitch-detection stage.

Parameters:
- CLK_DIV, 4: clk cycles per mic_clk period; even, at least 4.
- DECIM, 1024: PDM bits per channel per output sample.
- SAMPLE_W, 10: width of the output sample.
- DEPTH, 2048: number of RAM words written per single-shot capture; must be even when in stereo.
- ADDR_W, 11: RAM address width; must satisfy 2^ADDR_W >= DEPTH.
- WARMUP_FRAMES, 2: frames decimated but discarded after each start.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  one-cycle capture request
- stop  in  1  one-cycle abort/terminate request
- continuous  in  1  1 = ring-buffer mode; sampled at start
- stereo  in  1  1 = capture both channels; sampled at start
- mono_ch  in  1  channel used in mono mode (0 = L, 1 = R); sampled at start
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle completion pulse
- mic_clk  out  1  PDM clock to the microphones
- mic_lr_sel  out  1  L/R select pin of the microphone
- mic_data  in  1  PDM data from the microphones
- wr_en  out  1  RAM write strobe
- wr_addr  out  ADDR_W  RAM write address
- wr_data  out  SAMPLE_W  decimated sample
- wr_ch  out  1  channel of the current write (0 = L, 1 = R)

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; phase, frame and address counters 0.
- mic_clk is free-running from reset. Phase counter p runs 0..CLK_DIV-1; mic_clk = (p < CLK_DIV/2).
- Sampling ticks:
  - rise_tick at p == 0: sample the right channel.
  - fall_tick at p == CLK_DIV/2: sample the left channel.
- mic_lr_sel:
  - mono: the latched mono_ch.
  - stereo: 0 (two mics are hard-strapped).
- FSM states: IDLE, ALIGN, WARMUP, CAPTURE, DONE.
  - IDLE + start: latch configuration and go to ALIGN. busy = 1 in all states except IDLE. start is ignored outside IDLE.
  - ALIGN: wait for the next rise_tick. On that cycle clear the accumulators and the frame-bit counter, then go to WARMUP, or directly to CAPTURE if WARMUP_FRAMES == 0.
- Accumulation:
  - Each active channel adds mic_data to its ones-counter at its own tick.
  - A frame ends at the fall_tick that completes DECIM mic_clk periods.
  - sample = min(ones, 2^SAMPLE_W - 1), so DECIM = 1024 with SAMPLE_W = 10 saturates to 1023.
  - Accumulators restart at 0 for the next frame with no lost bits.
- WARMUP: counts WARMUP_FRAMES frame ends with no writes, then moves to CAPTURE.
- CAPTURE writes, per frame end:
  - mono: wr_en for 1 cycle, 1 cycle after the frame-ending fall_tick, with wr_ch = mono_ch.
  - stereo: L write at that cycle, R write on the next cycle.
  - wr_addr increments by 1 after every write.
- Single-shot:
  - After the write at address DEPTH-1, go to DONE.
  - DONE: done = 1 for one cycle, busy = 0 in the same cycle, then IDLE. The address resets to 0.
- Continuous:
  - Address wraps from DEPTH-1 to 0.
  - done is asserted only via stop.
- stop in any non-IDLE state:
  - Go to DONE on the next cycle and discard the partial frame.
  - A write pending on the same cycle as stop still completes; a stereo R write that is due completes first.
  - stop in IDLE is ignored.
  - start and stop on the same cycle in IDLE: start wins.
- Reset mid-operation aborts immediately: no further writes, the FSM goes to IDLE and the address returns to 0. mic_clk restarts at p = 0.

Test Plan:
All scenarios use CLK_DIV=4, DECIM=8, SAMPLE_W=3, DEPTH=4, ADDR_W=2, WARMUP_FRAMES=1.
1. Reset held 3 cycles, then released -> all outputs 0 during reset; mic_clk pattern 1,1,0,0 repeating from the first cycle after release.
2. Mono L, single-shot, mic_data=1 constant -> no write during warmup; 4 writes of data 7 (8 saturated) at addresses 0,1,2,3 spaced 32 cycles apart with wr_ch=0; done pulse 1 cycle after the last write; busy falls with done.
3. Stereo single-shot, mic_data=1 at rise_ticks and 0 at fall_ticks -> writes (addr,ch,data) = (0,L,0), (1,R,7), (2,L,0), (3,R,7) with the L/R writes on back-to-back cycles; then done.
4. Continuous mono R, mic_data alternating 1/0 per R tick -> data 4 on every write; addresses 0,1,2,3,0,1; stop pulse -> no further wr_en; done on the next cycle; busy=0.
5. rst_n low during CAPTURE at address 2 -> wr_en=0, busy=0; the next start writes from address 0.
6. start pulsed during CAPTURE -> ignored (no change to address or state); start+stop together in IDLE -> capture begins.

Source files
------------

// File: rtl/pdm_audio_capture.sv
`default_nettype none
// ============================================================================
// Module   : pdm_audio_capture
// Purpose  : PDM mic clock generator and ones-count decimator writing PCM
//            samples (mono or stereo, single-shot or ring) into sample RAM.
// Revision : 1.0 - initial release
// ============================================================================
module pdm_audio_capture #(
    parameter int CLK_DIV       = 4,
    parameter int DECIM         = 1024,
    parameter int SAMPLE_W      = 10,
    parameter int DEPTH         = 2048,
    parameter int ADDR_W        = 11,
    parameter int WARMUP_FRAMES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                stop,
    input  logic                continuous,
    input  logic                stereo,
    input  logic                mono_ch,
    output logic                busy,
    output logic                done,
    output logic                mic_clk,
    output logic                mic_lr_sel,
    input  logic                mic_data,
    output logic                wr_en,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [SAMPLE_W-1:0] wr_data,
    output logic                wr_ch
);

    localparam int C_HALF  = CLK_DIV / 2;
    localparam int C_PH_W  = $clog2(CLK_DIV);
    localparam int C_ACC_W = $clog2(DECIM + 1);
    localparam int C_PER_W = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int C_WF_W  = (WARMUP_FRAMES > 0) ? $clog2(WARMUP_FRAMES + 1) : 1;
    localparam int C_SMAX  = (1 << SAMPLE_W) - 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ALIGN   = 3'd1,
        S_WARMUP  = 3'd2,
        S_CAPTURE = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t               state_q;
    logic                 run_q;
    logic [C_PH_W-1:0]    ph_q;
    logic [C_ACC_W-1:0]   acc_l_q, acc_r_q;
    logic [C_PER_W-1:0]   per_q;
    logic [C_WF_W-1:0]    wf_q;
    logic [ADDR_W-1:0]    addr_q;
    logic [SAMPLE_W-1:0]  wr_data_q, samp_r_q;
    logic                 stereo_q, mono_q, cont_q;
    logic                 busy_q, done_q, wr_en_q, wr_ch_q, r_pend_q, stop_pend_q;

    logic                 w_rise, w_fall, w_add_l, w_add_r, w_active, w_frame_end, w_last;
    logic [C_ACC_W-1:0]   w_ones_l;

    function automatic logic [SAMPLE_W-1:0] sat(input logic [C_ACC_W-1:0] v);
        if (32'(v) > C_SMAX)
            return SAMPLE_W'(C_SMAX);
        else
            return SAMPLE_W'(v);
    endfunction

    // run_q holds the phase at 0 for the first cycle after reset release
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run_q <= 1'b0;
            ph_q  <= '0;
        end else begin
            run_q <= 1'b1;
            if (run_q)
                ph_q <= (ph_q == C_PH_W'(CLK_DIV - 1)) ? '0 : ph_q + 1'b1;
        end
    end

    assign mic_clk     = run_q && (ph_q < C_PH_W'(C_HALF));
    assign w_rise      = run_q && (ph_q == '0);
    assign w_fall      = run_q && (ph_q == C_PH_W'(C_HALF));
    assign w_add_l     = mic_data & (stereo_q | ~mono_q);
    assign w_add_r     = mic_data & (stereo_q | mono_q);
    assign w_ones_l    = acc_l_q + C_ACC_W'(w_add_l);
    assign w_active    = (state_q == S_WARMUP) || (state_q == S_CAPTURE);
    assign w_frame_end = w_active && w_fall && (per_q == C_PER_W'(DECIM - 1));
    assign w_last      = wr_en_q && !cont_q && (addr_q == ADDR_W'(DEPTH - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            acc_l_q     <= '0;
            acc_r_q     <= '0;
            per_q       <= '0;
            wf_q        <= '0;
            addr_q      <= '0;
            wr_data_q   <= '0;
            samp_r_q    <= '0;
            stereo_q    <= 1'b0;
            mono_q      <= 1'b0;
            cont_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_ch_q     <= 1'b0;
            r_pend_q    <= 1'b0;
            stop_pend_q <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;

            // Frames run back to back: the frame-end fall tick restarts both counters
            if (w_active) begin
                if (w_rise && w_add_r)
                    acc_r_q <= acc_r_q + 1'b1;
                if (w_fall) begin
                    if (w_frame_end) begin
                        acc_l_q <= '0;
                        acc_r_q <= '0;
                        per_q   <= '0;
                    end else begin
                        acc_l_q <= w_ones_l;
                        per_q   <= per_q + 1'b1;
                    end
                end
            end

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        stereo_q <= stereo;
                        mono_q   <= mono_ch;
                        cont_q   <= continuous;
                        busy_q   <= 1'b1;
                        state_q  <= S_ALIGN;
                    end
                end
                S_ALIGN: begin
                    if (stop) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        addr_q  <= '0;
                    end else if (w_rise) begin
                        acc_l_q <= '0;
                        acc_r_q <= C_ACC_W'(w_add_r);
                        per_q   <= '0;
                        wf_q    <= '0;
                        state_q <= (WARMUP_FRAMES == 0) ? S_CAPTURE : S_WARMUP;
                    end
                end
                S_WARMUP: begin
                    if (stop) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        addr_q  <= '0;
                    end else if (w_frame_end) begin
                        wf_q <= wf_q + 1'b1;
                        if (32'(wf_q) + 1 == WARMUP_FRAMES)
                            state_q <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    if (wr_en_q)
                        addr_q <= (addr_q == ADDR_W'(DEPTH - 1)) ? '0 : addr_q + 1'b1;
                    // A due R write is flushed before a stop takes effect
                    if (r_pend_q) begin
                        wr_en_q   <= 1'b1;
                        wr_ch_q   <= 1'b1;
                        wr_data_q <= samp_r_q;
                        r_pend_q  <= 1'b0;
                        if (stop)
                            stop_pend_q <= 1'b1;
                    end else if (stop || stop_pend_q || w_last) begin
                        state_q     <= S_DONE;
                        done_q      <= 1'b1;
                        busy_q      <= 1'b0;
                        addr_q      <= '0;
                        stop_pend_q <= 1'b0;
                    end else if (w_frame_end) begin
                        wr_en_q <= 1'b1;
                        if (stereo_q) begin
                            wr_ch_q   <= 1'b0;
                            wr_data_q <= sat(w_ones_l);
                            samp_r_q  <= sat(acc_r_q);
                            r_pend_q  <= 1'b1;
                        end else begin
                            wr_ch_q   <= mono_q;
                            wr_data_q <= mono_q ? sat(acc_r_q) : sat(w_ones_l);
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign mic_lr_sel = ~stereo_q & mono_q;
    assign wr_en      = wr_en_q;
    assign wr_addr    = addr_q;
    assign wr_data    = wr_data_q;
    assign wr_ch      = wr_ch_q;

endmodule
`default_nettype wire

// File: tb/tb_pdm_audio_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_pdm_audio_capture
// Purpose  : Scoreboard bench for pdm_audio_capture with small parameters.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pdm_audio_capture;

    localparam int CLK_DIV       = 4;
    localparam int DECIM         = 8;
    localparam int SAMPLE_W      = 3;
    localparam int DEPTH         = 4;
    localparam int ADDR_W        = 2;
    localparam int WARMUP_FRAMES = 1;
    localparam int FRAME_CYC     = DECIM * CLK_DIV;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                start = 1'b0;
    logic                stop = 1'b0;
    logic                continuous = 1'b0;
    logic                stereo = 1'b0;
    logic                mono_ch = 1'b0;
    logic                mic_data = 1'b0;
    logic                busy, done, mic_clk, mic_lr_sel, wr_en, wr_ch;
    logic [ADDR_W-1:0]   wr_addr;
    logic [SAMPLE_W-1:0] wr_data;

    pdm_audio_capture #(
        .CLK_DIV(CLK_DIV), .DECIM(DECIM), .SAMPLE_W(SAMPLE_W),
        .DEPTH(DEPTH), .ADDR_W(ADDR_W), .WARMUP_FRAMES(WARMUP_FRAMES)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .continuous(continuous), .stereo(stereo), .mono_ch(mono_ch),
        .busy(busy), .done(done), .mic_clk(mic_clk), .mic_lr_sel(mic_lr_sel),
        .mic_data(mic_data), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_ch(wr_ch)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0]   addr;
        logic                ch;
        logic [SAMPLE_W-1:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  failures = 0;
    int  cyc = 0;
    int  nwrites = 0;
    int  first_wr_cyc = 0;
    int  last_wr_cyc = 0;
    int  prev_wr_cyc = 0;
    int  mode = 0;
    logic prev_mc = 1'b0;
    logic alt = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // mic_data source: 0 = zeros, 1 = ones, 2 = follows mic_clk, 3 = toggles per R tick
    always @(negedge clk) begin
        case (mode)
            0: mic_data = 1'b0;
            1: mic_data = 1'b1;
            2: mic_data = mic_clk;
            3: if (mic_clk && !prev_mc) begin
                   alt = ~alt;
                   mic_data = alt;
               end
            default: mic_data = 1'b0;
        endcase
        prev_mc = mic_clk;
    end

    // Scoreboard: every observed write pops one expected entry
    always @(negedge clk) begin
        if (wr_en) begin
            wr_t e;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write got addr=%0d ch=%0d data=%0d, queue empty",
                         wr_addr, wr_ch, wr_data);
            end else begin
                e = exp_q.pop_front();
                if ({wr_addr, wr_ch, wr_data} !== e) begin
                    failures++;
                    $display("FAIL write_%0d got addr=%0d ch=%0d data=%0d expected addr=%0d ch=%0d data=%0d",
                             nwrites, wr_addr, wr_ch, wr_data, e.addr, e.ch, e.data);
                end
            end
            if (nwrites == 0) first_wr_cyc = cyc;
            prev_wr_cyc = last_wr_cyc;
            last_wr_cyc = cyc;
            nwrites++;
        end
    end

    task automatic push_wr(input int a, input bit ch, input int d);
        exp_q.push_back(wr_t'{ADDR_W'(a), ch, SAMPLE_W'(d)});
    endtask

    task automatic pulse_start(input bit cont, input bit st, input bit mch, input bit stp);
        @(negedge clk);
        continuous = cont; stereo = st; mono_ch = mch; start = 1'b1; stop = stp;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
    endtask

    task automatic wait_done(input int max, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_writes(input int n, input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (nwrites >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        logic [10:0] outs;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            outs = {busy, done, mic_clk, mic_lr_sel, wr_en, wr_addr, wr_data, wr_ch};
            checks++;
            if (outs !== '0) begin
                failures++;
                $display("FAIL reset_outputs cycle %0d got %b expected all zero", i, outs);
            end
        end
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (mic_clk !== ((i % 4) < 2)) begin
                failures++;
                $display("FAIL mic_clk_pattern cycle %0d got %b expected %b", i, mic_clk, ((i % 4) < 2));
            end
        end
    endtask

    task automatic test_mono_single;
        bit seen;
        int start_c;
        exp_q.delete(); nwrites = 0; mode = 1;
        for (int a = 0; a < 4; a++) push_wr(a, 1'b0, 7);
        pulse_start(1'b0, 1'b0, 1'b0, 1'b0);
        start_c = cyc;
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL mono_busy got %b expected 1", busy); end
        wait_done(400, seen);
        checks++;
        if (!seen) begin failures++; $display("FAIL mono_done_timeout got no done expected done"); end
        checks++;
        if (nwrites != 4 || exp_q.size() != 0) begin
            failures++; $display("FAIL mono_write_count got %0d expected 4", nwrites);
        end
        checks++;
        if (cyc - last_wr_cyc != 1) begin
            failures++; $display("FAIL mono_done_latency got %0d expected 1", cyc - last_wr_cyc);
        end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL mono_busy_with_done got %b expected 0", busy); end
        checks++;
        if (last_wr_cyc - prev_wr_cyc != FRAME_CYC) begin
            failures++; $display("FAIL mono_spacing got %0d expected %0d", last_wr_cyc - prev_wr_cyc, FRAME_CYC);
        end
        checks++;
        if (first_wr_cyc - start_c < 2 * FRAME_CYC - 4 || first_wr_cyc - start_c > 2 * FRAME_CYC + 16) begin
            failures++; $display("FAIL mono_warmup_delay got %0d expected about %0d", first_wr_cyc - start_c, 2 * FRAME_CYC);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin failures++; $display("FAIL mono_done_width got %b expected 0", done); end
    endtask

    task automatic test_back_to_back;
        bit seen;
        exp_q.delete(); nwrites = 0; mode = 2;
        push_wr(0, 1'b0, 0); push_wr(1, 1'b1, 7); push_wr(2, 1'b0, 0); push_wr(3, 1'b1, 7);
        pulse_start(1'b0, 1'b1, 1'b1, 1'b0);
        checks++;
        if (mic_lr_sel !== 1'b0) begin failures++; $display("FAIL stereo_lr_sel got %b expected 0", mic_lr_sel); end
        wait_done(400, seen);
        checks++;
        if (!seen || exp_q.size() != 0) begin
            failures++; $display("FAIL stereo_done got seen=%0d left=%0d expected seen=1 left=0", seen, exp_q.size());
        end
        checks++;
        if (last_wr_cyc - prev_wr_cyc != 1) begin
            failures++; $display("FAIL stereo_lr_gap got %0d expected 1", last_wr_cyc - prev_wr_cyc);
        end
        checks++;
        if (cyc - last_wr_cyc != 1) begin
            failures++; $display("FAIL stereo_done_latency got %0d expected 1", cyc - last_wr_cyc);
        end
    endtask

    task automatic test_continuous;
        bit ok;
        exp_q.delete(); nwrites = 0; mode = 3;
        for (int i = 0; i < 6; i++) push_wr(i % 4, 1'b1, 4);
        pulse_start(1'b1, 1'b0, 1'b1, 1'b0);
        checks++;
        if (mic_lr_sel !== 1'b1) begin failures++; $display("FAIL cont_lr_sel got %b expected 1", mic_lr_sel); end
        wait_writes(6, 500, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL cont_write_timeout got %0d writes expected 6", nwrites); end
        checks++;
        if (last_wr_cyc - prev_wr_cyc != FRAME_CYC) begin
            failures++; $display("FAIL cont_wrap_spacing got %0d expected %0d", last_wr_cyc - prev_wr_cyc, FRAME_CYC);
        end
        repeat (5) @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            failures++; $display("FAIL cont_stop got done=%b busy=%b expected done=1 busy=0", done, busy);
        end
        repeat (2 * FRAME_CYC) @(negedge clk);
        checks++;
        if (nwrites != 6 || busy !== 1'b0) begin
            failures++; $display("FAIL cont_after_stop got writes=%0d busy=%b expected writes=6 busy=0", nwrites, busy);
        end
    endtask

    task automatic test_reset_mid;
        bit ok;
        bit seen;
        exp_q.delete(); nwrites = 0; mode = 1;
        push_wr(0, 1'b0, 7); push_wr(1, 1'b0, 7);
        pulse_start(1'b0, 1'b0, 1'b0, 1'b0);
        wait_writes(2, 300, ok);
        repeat (8) @(negedge clk);
        checks++;
        if (!ok || wr_addr !== 2'd2) begin
            failures++; $display("FAIL midreset_addr got %0d expected 2", wr_addr);
        end
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (wr_en !== 1'b0 || busy !== 1'b0 || wr_addr !== 2'd0) begin
            failures++; $display("FAIL midreset_state got wr_en=%b busy=%b addr=%0d expected 0 0 0", wr_en, busy, wr_addr);
        end
        rst_n = 1'b1;
        for (int a = 0; a < 4; a++) push_wr(a, 1'b0, 7);
        pulse_start(1'b0, 1'b0, 1'b0, 1'b0);
        wait_done(400, seen);
        checks++;
        if (!seen || exp_q.size() != 0) begin
            failures++; $display("FAIL midreset_restart got seen=%0d left=%0d expected seen=1 left=0", seen, exp_q.size());
        end
    endtask

    task automatic test_start_ignored;
        bit ok;
        bit seen;
        exp_q.delete(); nwrites = 0; mode = 1;
        for (int a = 0; a < 4; a++) push_wr(a, 1'b0, 7);
        pulse_start(1'b0, 1'b0, 1'b0, 1'b0);
        wait_writes(1, 300, ok);
        pulse_start(1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (!ok || busy !== 1'b1 || mic_lr_sel !== 1'b0 || wr_addr !== 2'd1) begin
            failures++; $display("FAIL start_ignored got busy=%b lr=%b addr=%0d expected 1 0 1", busy, mic_lr_sel, wr_addr);
        end
        wait_done(400, seen);
        checks++;
        if (!seen || exp_q.size() != 0 || last_wr_cyc - prev_wr_cyc != FRAME_CYC) begin
            failures++; $display("FAIL start_ignored_run got seen=%0d left=%0d gap=%0d expected 1 0 %0d",
                                 seen, exp_q.size(), last_wr_cyc - prev_wr_cyc, FRAME_CYC);
        end
        @(negedge clk);
        nwrites = 0;
        for (int a = 0; a < 4; a++) push_wr(a, 1'b0, 7);
        pulse_start(1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            failures++; $display("FAIL start_stop_idle got busy=%b done=%b expected busy=1 done=0", busy, done);
        end
        wait_done(400, seen);
        checks++;
        if (!seen || nwrites != 4 || exp_q.size() != 0) begin
            failures++; $display("FAIL start_stop_run got seen=%0d writes=%0d expected seen=1 writes=4", seen, nwrites);
        end
    endtask

    initial begin
        test_reset;
        test_mono_single;
        test_back_to_back;
        test_continuous;
        test_reset_mid;
        test_start_ignored;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
